// File: rtl/tcdm_bank_arbiter.sv
// rtl/tcdm_bank_arbiter.sv - round-robin arbiter granting NB_REQ requesters access to one TCDM bank
// Optional power-on zeroing of the bank is enabled by defining TCDM_ARB_SCRUB_EN.
module tcdm_bank_arbiter #(
   parameter int unsigned NB_REQ     = 4,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8,
   localparam int unsigned IDX_W     = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NB_REQ-1:0]                     req_i,
   input  logic [NB_REQ-1:0]                     wen_i,
   input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]     add_i,
   input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]     data_i,
   input  logic [NB_REQ-1:0][BE_WIDTH-1:0]       be_i,
   output logic [NB_REQ-1:0]                     gnt_o,
   output logic [NB_REQ-1:0]                     r_valid_o,
   output logic [DATA_WIDTH-1:0]                 r_data_o,
   output logic                                  bank_req_o,
   output logic                                  bank_we_o,
   output logic [ADDR_WIDTH-1:0]                 bank_add_o,
   output logic [DATA_WIDTH-1:0]                 bank_wdata_o,
   output logic [BE_WIDTH-1:0]                   bank_be_o,
   input  logic [DATA_WIDTH-1:0]                 bank_rdata_i,
   output logic                                  init_done_o
);

   logic              arb_en;
   logic              found;
   logic              found_g;
   logic [IDX_W-1:0]  winner;
   logic [IDX_W-1:0]  rr_q;
   logic [IDX_W-1:0]  rr_d;
   logic [NB_REQ-1:0] r_valid_q;

`ifdef TCDM_ARB_SCRUB_EN
   typedef enum logic {SCRUB, ARB} state_e;

   state_e                state_q;
   state_e                state_d;
   logic [ADDR_WIDTH-1:0] scrub_cnt_q;
   logic [ADDR_WIDTH-1:0] scrub_cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= SCRUB;
         scrub_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         scrub_cnt_q <= scrub_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      scrub_cnt_d = scrub_cnt_q;
      case (state_q)
         SCRUB: begin
            scrub_cnt_d = scrub_cnt_q + 1'b1;
            if (&scrub_cnt_q) state_d = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   assign arb_en      = (state_q == ARB);
   assign init_done_o = arb_en;
`else
   assign arb_en      = 1'b1;
   assign init_done_o = 1'b1;
`endif

   // First requester at or above rr_q, wrapping around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int unsigned i = 0; i < NB_REQ; i++) begin
         if (!found && req_i[IDX_W'((32'(rr_q) + i) % NB_REQ)]) begin
            found  = 1'b1;
            winner = IDX_W'((32'(rr_q) + i) % NB_REQ);
         end
      end
   end

   // Reset gating keeps grants and bank requests quiet while rst_ni is low.
   assign found_g = found && arb_en && rst_ni;
   assign gnt_o   = found_g ? (NB_REQ'(1) << winner) : '0;

   always_comb begin
      bank_req_o   = found_g;
      bank_we_o    = ~wen_i[winner];
      bank_add_o   = add_i[winner];
      bank_wdata_o = data_i[winner];
      bank_be_o    = be_i[winner];
`ifdef TCDM_ARB_SCRUB_EN
      if (state_q == SCRUB) begin
         bank_req_o   = rst_ni;
         bank_we_o    = 1'b1;
         bank_add_o   = scrub_cnt_q;
         bank_wdata_o = '0;
         bank_be_o    = '1;
      end
`endif
   end

   always_comb begin
      rr_d = rr_q;
      if (found_g) rr_d = (winner == IDX_W'(NB_REQ - 1)) ? '0 : winner + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q      <= '0;
         r_valid_q <= '0;
      end else begin
         rr_q      <= rr_d;
         r_valid_q <= gnt_o;
      end
   end

   assign r_valid_o = r_valid_q;
   assign r_data_o  = bank_rdata_i;

endmodule

// File: doc/tcdm_bank_arbiter.md
TCDM_BANK_ARBITER -- requirements
Module: tcdm_bank_arbiter

Interface
REQ-001 Parameter NB_REQ, default 4: number of requesters sharing one bank; SHALL be >= 2.
REQ-002 Parameter ADDR_WIDTH, default 8: bank word-address width; bank depth is 2^ADDR_WIDTH words.
REQ-003 Parameter DATA_WIDTH, default 32: word width; byte-enable width BE_WIDTH = DATA_WIDTH/8.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_i  input  NB_REQ  per-requester request.
REQ-007 wen_i  input  NB_REQ  per-requester write enable, active-low (0 = write, 1 = read).
REQ-008 add_i  input  NB_REQ x ADDR_WIDTH  per-requester word address.
REQ-009 data_i  input  NB_REQ x DATA_WIDTH  per-requester write data.
REQ-010 be_i  input  NB_REQ x BE_WIDTH  per-requester byte enables.
REQ-011 gnt_o  output  NB_REQ  per-requester grant, one-hot or zero.
REQ-012 r_valid_o  output  NB_REQ  per-requester response valid.
REQ-013 r_data_o  output  DATA_WIDTH  read data, shared by all requesters.
REQ-014 bank_req_o  output  1  bank request.
REQ-015 bank_we_o  output  1  bank write enable, active-high.
REQ-016 bank_add_o  output  ADDR_WIDTH  bank word address.
REQ-017 bank_wdata_o  output  DATA_WIDTH  bank write data.
REQ-018 bank_be_o  output  BE_WIDTH  bank byte enables.
REQ-019 bank_rdata_i  input  DATA_WIDTH  bank read data, valid one cycle after a bank read.
REQ-020 init_done_o  output  1  high once the block accepts requests.

Function
REQ-021 The FSM has two states: SCRUB and ARB; ARB is the only state in which gnt_o can be non-zero.
REQ-022 In ARB, the winner is the first set bit of req_i searched from pointer rr_q upward, wrapping from NB_REQ-1 to 0.
REQ-023 Grant is combinational: gnt_o[winner]=1 in the same cycle req_i is seen; gnt_o=0 when no req_i bit is set.
REQ-024 On a grant, bank_req_o=1 and bank_add_o/bank_wdata_o/bank_be_o are the winner's inputs; bank_we_o = ~wen_i[winner].
REQ-025 After a grant to index k, rr_q becomes (k+1) mod NB_REQ; with no grant, rr_q holds.
REQ-026 r_valid_o[k]=1 exactly one cycle after a grant to k, for both reads and writes; otherwise 0.
REQ-027 r_data_o = bank_rdata_i and is meaningful only while some r_valid_o bit is set.
REQ-028 Back-to-back grants are allowed every cycle; throughput is one access per cycle.
REQ-029 A requester that holds req_i while not granted SHALL be granted within NB_REQ cycles.
REQ-030 With no grant, bank_req_o=0 and the other bank_* outputs are don't-care.

Reset
REQ-031 While rst_ni=0: gnt_o=0, r_valid_o=0, bank_req_o=0, rr_q=0, scrub counter=0.
REQ-032 The FSM resets to SCRUB when TCDM_ARB_SCRUB_EN is defined, otherwise to ARB. Assertion of rst_ni mid-scrub or mid-access restarts from that state, and any pending r_valid_o is dropped.

Configuration
REQ-033 Macro TCDM_ARB_SCRUB_EN defined: SCRUB writes zero to addresses 0..2^ADDR_WIDTH-1, one per cycle, with bank_req_o=1, bank_we_o=1, bank_be_o all ones and gnt_o=0. The FSM enters ARB in the cycle after the last address. init_done_o=0 in SCRUB and 1 in ARB.
REQ-034 Macro TCDM_ARB_SCRUB_EN undefined: no SCRUB state or counter logic is present, and init_done_o is tied to 1.

Verification
REQ-035 Scrub: with TCDM_ARB_SCRUB_EN defined and ADDR_WIDTH=8, release reset -> 256 zero writes to addresses 0..255, then init_done_o=1 at cycle 257; req_i is ignored throughout.
REQ-036 Fairness: NB_REQ=4, req_i=4'b1111 held for 8 cycles -> grants go to 0,1,2,3,0,1,2,3.
REQ-037 Read latency: write 0xDEADBEEF with be=4'hF to address 0x10 from requester 2, then read 0x10 from requester 1 -> r_valid_o=4'b0010 one cycle after the grant, with r_data_o=0xDEADBEEF.
REQ-038 Byte enables: write 0x11223344 with be=4'b0101 over zeroed memory, then read back -> 0x00220044.
REQ-039 Wrap: rr_q=3 with req_i=4'b0101 -> grant to 0, then rr_q=1.
REQ-040 Reset mid-access: assert rst_ni=0 in the cycle after a read grant -> r_valid_o stays 0 and rr_q=0.
